// File: rtl/prbs_gen_multi_if.sv
// Purpose: control/data bundle between the PRBS source and its user.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer must accept every group flagged by valid_o.
//
// Ports: clk_en, load_i, order_i, seed_i, inj_i flow master -> slave;
//        data_o, valid_o, cfg_err_o, order_o, grp_cnt_o flow slave -> master.
interface prbs_gen_multi_if #(
    parameter int N_LANES = 4
);
    logic               clk_en;
    logic               load_i;
    logic [2:0]         order_i;
    logic [31:0]        seed_i;
    logic               inj_i;
    logic [N_LANES-1:0] data_o;
    logic               valid_o;
    logic               cfg_err_o;
    logic [2:0]         order_o;
    logic [31:0]        grp_cnt_o;

    modport master (
        output clk_en, load_i, order_i, seed_i, inj_i,
        input  data_o, valid_o, cfg_err_o, order_o, grp_cnt_o
    );

    modport slave (
        input  clk_en, load_i, order_i, seed_i, inj_i,
        output data_o, valid_o, cfg_err_o, order_o, grp_cnt_o
    );
endinterface

// File: rtl/prbs_gen_multi.sv
// Purpose: multi-lane PRBS source (orders 7/9/15/21/23/31) with seed load and single-bit error injection.
// Latency: 1 cycle from clk_en/load_i to data_o, valid_o, order_o, cfg_err_o and grp_cnt_o.
// Backpressure: none; every clk_en cycle advances N_LANES bits whether or not the consumer is ready.
//
// Ports: emu_clk, emu_rst_n (async, active-low) plain; bus (slave modport) carries
//        clk_en, load_i, order_i, seed_i, inj_i in and data_o (lane 0 earliest), valid_o,
//        cfg_err_o, order_o, grp_cnt_o out.
module prbs_gen_multi #(
    parameter int          N_LANES       = 4,
    parameter logic [2:0]  DEFAULT_ORDER = 3'd3,
    parameter logic [31:0] DEFAULT_SEED  = 32'hFFFF_FFFF
) (
    input  logic            emu_clk,
    input  logic            emu_rst_n,
    prbs_gen_multi_if.slave bus
);

    // Order table: index of the top register bit (L-1) and of the second tap (T-1).
    // Reserved codes fall back to the 21-bit entry so the datapath never sees an
    // out-of-range tap; they are never accepted into order_q anyway.
    function automatic logic [4:0] ord_len_m1(input logic [2:0] o);
        case (o)
            3'd0:    return 5'd6;
            3'd1:    return 5'd8;
            3'd2:    return 5'd14;
            3'd4:    return 5'd22;
            3'd5:    return 5'd30;
            default: return 5'd20;
        endcase
    endfunction

    function automatic logic [4:0] ord_tap_m1(input logic [2:0] o);
        case (o)
            3'd0:    return 5'd5;
            3'd1:    return 5'd4;
            3'd2:    return 5'd13;
            3'd4:    return 5'd17;
            3'd5:    return 5'd27;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [31:0] ord_mask(input logic [2:0] o);
        case (o)
            3'd0:    return 32'h0000_007F;
            3'd1:    return 32'h0000_01FF;
            3'd2:    return 32'h0000_7FFF;
            3'd4:    return 32'h007F_FFFF;
            3'd5:    return 32'h7FFF_FFFF;
            default: return 32'h001F_FFFF;
        endcase
    endfunction

    function automatic logic ord_reserved(input logic [2:0] o);
        return o[2] & o[1];
    endfunction

    // An all-zero state would lock the LFSR, so a seed that masks to zero becomes all-ones.
    function automatic logic [31:0] seed_fix(input logic [31:0] seed, input logic [2:0] o);
        logic [31:0] m;
        m = seed & ord_mask(o);
        return (m == 32'h0) ? ord_mask(o) : m;
    endfunction

    localparam logic [31:0] RST_SEED = seed_fix(DEFAULT_SEED, DEFAULT_ORDER);

    logic [31:0]        s_q, s_d;
    logic [2:0]         order_q, order_d;
    logic [N_LANES-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               cfg_err_q, cfg_err_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               pend_q, pend_d;

    logic [4:0]         len_m1;
    logic [4:0]         tap_m1;
    logic [31:0]        msk;
    logic [31:0]        walk;
    logic [N_LANES-1:0] lanes;
    logic               fb;
    logic               load_ok;
    logic               load_bad;
    logic               advance;
    logic               inj_now;

    assign len_m1   = ord_len_m1(order_q);
    assign tap_m1   = ord_tap_m1(order_q);
    assign msk      = ord_mask(order_q);
    assign load_ok  = bus.load_i & ~ord_reserved(bus.order_i);
    assign load_bad = bus.load_i &  ord_reserved(bus.order_i);
    // A valid load takes priority over an advance in the same cycle.
    assign advance  = bus.clk_en & ~load_ok;
    // An injection request arriving with the advance applies to that same group.
    assign inj_now  = pend_q | bus.inj_i;

    // N_LANES chained LFSR steps; lane k carries the feedback bit of step k.
    always_comb begin
        walk  = s_q;
        lanes = '0;
        fb    = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            fb       = walk[len_m1] ^ walk[tap_m1];
            lanes[k] = fb;
            walk     = {walk[30:0], fb} & msk;
        end
    end

    always_comb begin
        s_d       = s_q;
        order_d   = order_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        valid_d   = advance;
        cfg_err_d = load_bad;
        if (load_ok) begin
            order_d = bus.order_i;
            s_d     = seed_fix(bus.seed_i, bus.order_i);
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else if (advance) begin
            s_d       = walk;
            // Only the emitted bit is corrupted; the LFSR state stays clean.
            data_d    = lanes;
            data_d[0] = lanes[0] ^ inj_now;
            pend_d    = 1'b0;
            if (cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
        end else if (bus.inj_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            s_q       <= RST_SEED;
            order_q   <= DEFAULT_ORDER;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            s_q       <= s_d;
            order_q   <= order_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.cfg_err_o = cfg_err_q;
    assign bus.order_o   = order_q;
    assign bus.grp_cnt_o = cnt_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Purpose: self-checking bench for prbs_gen_multi with a 4-lane and a 1-lane instance.
// Latency: checks outputs 1 ns after the capturing edge.
// Backpressure: n/a.
module tb_prbs_gen_multi;

    logic emu_clk = 1'b0;
    logic emu_rst_n;
    always #5 emu_clk = ~emu_clk;

    prbs_gen_multi_if #(.N_LANES(4)) b4 ();
    prbs_gen_multi_if #(.N_LANES(1)) b1 ();

    prbs_gen_multi #(.N_LANES(4)) u4 (.emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .bus(b4));
    prbs_gen_multi #(.N_LANES(1)) u1 (.emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference LFSR, written from the polynomial table.
    logic [31:0] m_s;
    logic [2:0]  m_o;

    function automatic int mdl_len(input logic [2:0] o);
        case (o)
            3'd0: return 7;   3'd1: return 9;   3'd2: return 15;
            3'd3: return 21;  3'd4: return 23;  default: return 31;
        endcase
    endfunction

    function automatic int mdl_tap(input logic [2:0] o);
        case (o)
            3'd0: return 6;   3'd1: return 5;   3'd2: return 14;
            3'd3: return 2;   3'd4: return 18;  default: return 28;
        endcase
    endfunction

    task automatic mdl_load(input logic [2:0] o, input logic [31:0] seed);
        logic [31:0] mk;
        mk  = (32'h1 << mdl_len(o)) - 32'h1;
        m_o = o;
        m_s = seed & mk;
        if (m_s == 32'h0) m_s = mk;
    endtask

    task automatic mdl_step(output logic b);
        int l;
        int t;
        l   = mdl_len(m_o);
        t   = mdl_tap(m_o);
        b   = m_s[l-1] ^ m_s[t-1];
        m_s = {m_s[30:0], b} & ((32'h1 << l) - 32'h1);
    endtask

    task automatic mdl_grp(output logic [3:0] g);
        logic b;
        for (int k = 0; k < 4; k++) begin
            mdl_step(b);
            g[k] = b;
        end
    endtask

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    logic [31:0] seeds [6] = '{32'h0000_0055, 32'h0000_0123, 32'h0000_4ACE,
                               32'h0012_3456, 32'h0055_AA33, 32'h1357_9BDF};
    bit          strm[$];
    logic [20:0] sr;
    logic        fb;
    logic [3:0]  g;
    logic [6:0]  v7;
    logic [5:0]  v6;
    int          errs, perr, ones, hits, per, ngrp;

    initial begin
        b4.clk_en = 0; b4.load_i = 0; b4.order_i = 0; b4.seed_i = 0; b4.inj_i = 0;
        b1.clk_en = 0; b1.load_i = 0; b1.order_i = 0; b1.seed_i = 0; b1.inj_i = 0;
        emu_rst_n = 1'b0;
        repeat (2) tick();

        chk("rst_order",   {b4.order_o, b1.order_o}, {3'd3, 3'd3});
        chk("rst_data",    {b4.data_o, b1.data_o}, 5'h00);
        chk("rst_valid",   {b4.valid_o, b1.valid_o}, 2'b00);
        chk("rst_cfg_err", {b4.cfg_err_o, b1.cfg_err_o}, 2'b00);
        chk("rst_grp_cnt", b4.grp_cnt_o, 32'd0);
        emu_rst_n = 1'b1;
        tick();

        // Legacy 21-bit shift register comparison on the 1-lane instance.
        sr = '1;
        errs = 0;
        b1.clk_en = 1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            fb = sr[20] ^ sr[1];
            sr = {sr[19:0], fb};
            if (b1.data_o[0] !== fb || b1.valid_o !== 1'b1) errs++;
        end
        b1.clk_en = 0;
        chk("legacy21_stream", errs, 0);
        tick();
        chk("legacy21_grp_cnt", b1.grp_cnt_o, 32'd10000);
        chk("idle_valid", b1.valid_o, 1'b0);

        // PRBS7 from all-ones: six zeros then a one, period exactly 127.
        b1.load_i = 1; b1.order_i = 3'd0; b1.seed_i = 32'h7F;
        tick();
        b1.load_i = 0;
        chk("load7_state", {b1.order_o, b1.valid_o}, {3'd0, 1'b0});
        chk("load7_grp_clr", b1.grp_cnt_o, 32'd0);
        strm.delete();
        b1.clk_en = 1;
        for (int i = 0; i < 254; i++) begin
            tick();
            strm.push_back(b1.data_o[0]);
        end
        for (int k = 0; k < 7; k++) v7[k] = strm[k];
        chk("prbs7_first7", v7, 7'b1000000);
        perr = 0; ones = 0; hits = 0;
        for (int i = 0; i < 127; i++) begin
            if (strm[i] != strm[i+127]) perr++;
            ones += int'(strm[i]);
            if ({strm[i+6], strm[i+5], strm[i+4], strm[i+3], strm[i+2], strm[i+1], strm[i]} == 7'b1000000) hits++;
        end
        chk("prbs7_period", perr, 0);
        chk("prbs7_ones", ones, 64);
        chk("prbs7_seed_once", hits, 1);
        chk("prbs7_grp_cnt", b1.grp_cnt_o, 32'd254);

        // Zero seed on PRBS9 becomes 9'h1FF: five zeros then a one.
        b1.clk_en = 0;
        b1.load_i = 1; b1.order_i = 3'd1; b1.seed_i = 32'h0;
        tick();
        b1.load_i = 0;
        b1.clk_en = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            v6[i] = b1.data_o[0];
        end
        b1.clk_en = 0;
        chk("prbs9_zero_seed", v6, 6'b100000);

        // Reserved order codes: rejected, single-cycle error pulse.
        b1.load_i = 1; b1.order_i = 3'd6; b1.seed_i = 32'h123;
        tick();
        b1.load_i = 0;
        chk("rsv_cfg_err", b1.cfg_err_o, 1'b1);
        chk("rsv_hold", {b1.order_o, b1.valid_o, b1.data_o}, {3'd1, 1'b0, 1'b1});
        tick();
        chk("rsv_pulse_end", b1.cfg_err_o, 1'b0);
        // State is 9'h1C1 here, so the next bit is s[8]^s[4] = 1.
        b1.load_i = 1; b1.order_i = 3'd7; b1.clk_en = 1;
        tick();
        b1.load_i = 0; b1.clk_en = 0;
        chk("rsv_with_adv", {b1.cfg_err_o, b1.valid_o, b1.data_o, b1.grp_cnt_o[3:0]}, {1'b1, 1'b1, 1'b1, 4'd7});

        // Load and clk_en together: load wins, no advance, data held.
        b1.load_i = 1; b1.order_i = 3'd0; b1.seed_i = 32'hFF; b1.clk_en = 1;
        tick();
        b1.load_i = 0;
        chk("load_wins", {b1.valid_o, b1.data_o, b1.order_o}, {1'b0, 1'b1, 3'd0});
        chk("load_wins_cnt", b1.grp_cnt_o, 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            v7[i] = b1.data_o[0];
        end
        b1.clk_en = 0;
        chk("load_wins_restart", v7, 7'b1000000);

        // 4-lane instance against the serial reference for every order.
        for (int o = 0; o < 6; o++) begin
            b4.load_i = 1; b4.order_i = o[2:0]; b4.seed_i = seeds[o];
            tick();
            b4.load_i = 0;
            mdl_load(o[2:0], seeds[o]);
            per  = (1 << mdl_len(o[2:0])) - 1;
            ngrp = (o <= 2) ? (2 * per) / 4 + 1 : 64;
            strm.delete();
            errs = 0;
            b4.clk_en = 1;
            for (int gi = 0; gi < ngrp; gi++) begin
                tick();
                for (int k = 0; k < 4; k++) begin
                    mdl_step(fb);
                    if (b4.data_o[k] !== fb) errs++;
                    strm.push_back(b4.data_o[k]);
                end
                if (b4.valid_o !== 1'b1) errs++;
            end
            b4.clk_en = 0;
            chk($sformatf("lanes4_order%0d", o), errs, 0);
            if (o <= 2) begin
                perr = 0; ones = 0;
                for (int i = 0; i < per; i++) begin
                    if (strm[i] != strm[i+per]) perr++;
                    ones += int'(strm[i]);
                end
                chk($sformatf("period_order%0d", o), perr, 0);
                chk($sformatf("ones_order%0d", o), ones, (per + 1) / 2);
            end
        end
        chk("lanes4_grp_cnt", b4.grp_cnt_o, 32'd64);

        // Injection: pending across idle cycles, flips lane 0 only.
        b4.load_i = 1; b4.order_i = 3'd3; b4.seed_i = 32'hFFFF_FFFF;
        tick();
        b4.load_i = 0;
        mdl_load(3'd3, 32'hFFFF_FFFF);
        b4.inj_i = 1;
        tick();
        b4.inj_i = 0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b4.valid_o !== 1'b0) errs++;
        end
        chk("inj_idle_hold", errs, 0);
        b4.clk_en = 1;
        tick();
        mdl_grp(g);
        chk("inj_first_group", b4.data_o, 4'hD);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mdl_grp(g);
            if (b4.data_o !== g) errs++;
        end
        b4.clk_en = 0;
        chk("inj_state_clean", errs, 0);

        b4.inj_i = 1;
        tick();
        tick();
        b4.inj_i = 0;
        b4.clk_en = 1;
        tick();
        mdl_grp(g);
        g[0] = ~g[0];
        chk("inj_single_flip", b4.data_o, g);
        tick();
        mdl_grp(g);
        chk("inj_no_stack", b4.data_o, g);

        b4.inj_i = 1;
        tick();
        b4.inj_i = 0;
        mdl_grp(g);
        g[0] = ~g[0];
        chk("inj_same_cycle", b4.data_o, g);
        tick();
        mdl_grp(g);
        b4.clk_en = 0;
        chk("inj_same_after", b4.data_o, g);

        b4.inj_i = 1;
        tick();
        b4.inj_i = 0;
        b4.load_i = 1; b4.order_i = 3'd3; b4.seed_i = 32'hFFFF_FFFF;
        tick();
        b4.load_i = 0;
        b4.clk_en = 1;
        tick();
        b4.clk_en = 0;
        chk("inj_cleared_by_load", b4.data_o, 4'hC);

        // Asynchronous reset in the middle of a running stream.
        b4.load_i = 1; b4.order_i = 3'd5; b4.seed_i = 32'h1;
        tick();
        b4.load_i = 0;
        b4.clk_en = 1;
        repeat (3) tick();
        emu_rst_n = 1'b0;
        #2;
        chk("midrst_outputs", {b4.order_o, b4.valid_o, b4.cfg_err_o, b4.data_o}, {3'd3, 1'b0, 1'b0, 4'h0});
        chk("midrst_grp_cnt", b4.grp_cnt_o, 32'd0);
        tick();
        chk("midrst_held", {b4.valid_o, b4.data_o}, {1'b0, 4'h0});
        emu_rst_n = 1'b1;
        tick();
        chk("midrst_restart", {b4.valid_o, b4.data_o, b4.grp_cnt_o[3:0]}, {1'b1, 4'hC, 4'd1});
        mdl_load(3'd3, 32'hFFFF_FFFF);
        mdl_grp(g);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mdl_grp(g);
            if (b4.data_o !== g) errs++;
        end
        b4.clk_en = 0;
        chk("midrst_stream", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
